// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file micro-op sequencer.
// Opcodes, FSM states and width defaults; RF_SEQ_LDI_EN turns opcode 0 into LDI.
package rf_seq_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 2;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

`ifdef RF_SEQ_LDI_EN
  localparam bit LDI_EN = 1'b1;
`else
  localparam bit LDI_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: op, a, b, imm in; result, carry out.
// Opcode 0 yields imm when RF_SEQ_LDI_EN is defined, otherwise zero (no write).
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DW-1:0];
        carry  = wide[DW];
      end
      OP_SUB: begin
        // top bit of the widened difference is the borrow (a < b)
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DW-1:0];
        carry  = wide[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << b[4:0];
      OP_MOV: result = a;
      default: result = LDI_EN ? imm : '0;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Read/execute/write-back sequencer for a 4x32 register file.
// Ports: instr_* handshake in, rf_* file controls, done/result/flag_z/flag_c.
// Optional feature macro: RF_SEQ_LDI_EN (opcode 0 becomes LDI).
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [RW-1:0] instr_d,
  input  logic [RW-1:0] instr_a,
  input  logic [RW-1:0] instr_b,
  input  logic [DW-1:0] instr_imm,
  output logic [RW-1:0] rf_asel,
  output logic [RW-1:0] rf_bsel,
  output logic [RW-1:0] rf_dsel,
  output logic          rf_enable,
  output logic [DW-1:0] rf_ddata,
  input  logic [DW-1:0] rf_adata,
  input  logic [DW-1:0] rf_bdata,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_z,
  output logic          flag_c
);

  state_t        state;
  logic [2:0]    op_q;
  logic [RW-1:0] d_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          en_q;
  logic          done_q;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          writes;
  logic          sets_c;

  rf_seq_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (opa),
    .b      (opb),
    .imm    (imm_q),
    .result (alu_res),
    .carry  (alu_c)
  );

  assign writes = LDI_EN || (op_q != OP_NOP);
  assign sets_c = (op_q == OP_ADD) || (op_q == OP_SUB);

  assign instr_ready = (state == IDLE) && !rst;
  // a WRITE cycle that sees rst must not strobe the file
  assign rf_enable   = en_q && !rst;
  assign done        = done_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      d_q      <= '0;
      imm_q    <= '0;
      opa      <= '0;
      opb      <= '0;
      rf_asel  <= '0;
      rf_bsel  <= '0;
      rf_dsel  <= '0;
      rf_ddata <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q    <= instr_op;
            d_q     <= instr_d;
            imm_q   <= instr_imm;
            rf_asel <= instr_a;
            rf_bsel <= instr_b;
            state   <= READ;
          end
        end
        READ: begin
          opa   <= rf_adata;
          opb   <= rf_bdata;
          state <= EXEC;
        end
        EXEC: begin
          // results land in registers so WRITE presents them
          done_q  <= 1'b1;
          rf_dsel <= d_q;
          if (writes) begin
            en_q     <= 1'b1;
            rf_ddata <= alu_res;
            result   <= alu_res;
            flag_z   <= (alu_res == '0);
            flag_c   <= sets_c ? alu_c : 1'b0;
          end
          state <= WRITE;
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer with a behavioural register file.
// Honours RF_SEQ_LDI_EN the same way as the design build.
module tb_rf_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = '0;
  logic [1:0]  instr_d = '0;
  logic [1:0]  instr_a = '0;
  logic [1:0]  instr_b = '0;
  logic [31:0] instr_imm = '0;
  logic [1:0]  rf_asel, rf_bsel, rf_dsel;
  logic        rf_enable;
  logic [31:0] rf_ddata, rf_adata, rf_bdata;
  logic        done;
  logic [31:0] result;
  logic        flag_z, flag_c;

  logic [31:0] rf_mem [4];
  logic        seed_en = 1'b0;
  logic [1:0]  seed_idx = '0;
  logic [31:0] seed_val = '0;

  always #5 clk = ~clk;

  rf_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_d     (instr_d),
    .instr_a     (instr_a),
    .instr_b     (instr_b),
    .instr_imm   (instr_imm),
    .rf_asel     (rf_asel),
    .rf_bsel     (rf_bsel),
    .rf_dsel     (rf_dsel),
    .rf_enable   (rf_enable),
    .rf_ddata    (rf_ddata),
    .rf_adata    (rf_adata),
    .rf_bdata    (rf_bdata),
    .done        (done),
    .result      (result),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  // register file: combinational reads, clocked write
  assign rf_adata = rf_mem[rf_asel];
  assign rf_bdata = rf_mem[rf_bsel];
  always_ff @(posedge clk) begin
    if (seed_en) rf_mem[seed_idx] <= seed_val;
    else if (rf_enable) rf_mem[rf_dsel] <= rf_ddata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  d;
    logic [31:0] data;
    logic [31:0] res;
    bit          z;
    bit          c;
    int          acc;
  } exp_t;

  exp_t q[$];

  // reference state
  logic [31:0] m_rf [4];
  logic [31:0] m_res = '0;
  bit          m_z = 1'b0;
  bit          m_c = 1'b0;

  always @(negedge clk) begin
    if (rf_enable && !done) chk("enable_without_done", 1, 0);
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc - e.acc, 3);
        chk("rf_enable", {31'd0, rf_enable}, {31'd0, e.wr});
        if (e.wr) begin
          chk("rf_dsel", {30'd0, rf_dsel}, {30'd0, e.d});
          chk("rf_ddata", rf_ddata, e.data);
        end
        chk("result", result, e.res);
        chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
        chk("flag_c", {31'd0, flag_c}, {31'd0, e.c});
      end
    end
  end

  task automatic seed(int idx, logic [31:0] v);
    @(negedge clk);
    seed_en  = 1'b1;
    seed_idx = idx[1:0];
    seed_val = v;
    @(posedge clk);
    #1 seed_en = 1'b0;
    m_rf[idx] = v;
  endtask

  task automatic check_rf(string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_r%0d", tag, i), rf_mem[i], m_rf[i]);
  endtask

  // apply one instruction to the reference state and build the expectation
  task automatic model(input logic [2:0] op, input logic [1:0] d,
                       input logic [1:0] a, input logic [1:0] b,
                       input logic [31:0] imm, output exp_t e);
    logic [31:0] va, vb, v;
    logic [32:0] w;
    bit wr, c;
    va = m_rf[a];
    vb = m_rf[b];
    wr = 1'b1;
    c  = 1'b0;
    v  = '0;
    case (op)
      3'd1: begin w = {1'b0, va} + {1'b0, vb}; v = w[31:0]; c = w[32]; end
      3'd2: begin v = va - vb; c = (va < vb); end
      3'd3: v = va & vb;
      3'd4: v = va | vb;
      3'd5: v = va ^ vb;
      3'd6: v = va << vb[4:0];
      3'd7: v = va;
      default: begin
`ifdef RF_SEQ_LDI_EN
        v = imm;
`else
        wr = 1'b0;
`endif
      end
    endcase
    if (wr) begin
      m_rf[d] = v;
      m_res   = v;
      m_z     = (v == 0);
      m_c     = c;
    end
    e.wr   = wr;
    e.d    = d;
    e.data = v;
    e.res  = m_res;
    e.z    = m_z;
    e.c    = m_c;
    e.acc  = 0;
  endtask

  task automatic issue(logic [2:0] op, logic [1:0] d, logic [1:0] a,
                       logic [1:0] b, logic [31:0] imm, bit hold);
    exp_t e;
    @(negedge clk);
    chk("ready_before_issue", {31'd0, instr_ready}, 1);
    instr_op    = op;
    instr_d     = d;
    instr_a     = a;
    instr_b     = b;
    instr_imm   = imm;
    instr_valid = 1'b1;
    model(op, d, a, b, imm, e);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk);
    if (!hold) begin
      #1;
      instr_valid = 1'b0;
      instr_op    = 3'($urandom);
      instr_d     = 2'($urandom);
      instr_a     = 2'($urandom);
      instr_b     = 2'($urandom);
      instr_imm   = $urandom;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (hold) chk("ready_low_busy", {31'd0, instr_ready}, 0);
    end
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_retire", {31'd0, instr_ready}, 1);
    check_rf("rf");
  endtask

  task automatic abort(logic [2:0] op, logic [1:0] d, logic [1:0] a,
                       logic [1:0] b, bit in_write);
    @(negedge clk);
    instr_op    = op;
    instr_d     = d;
    instr_a     = a;
    instr_b     = b;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    if (in_write) begin
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_write_enable", {31'd0, rf_enable}, 0);
      chk("abort_write_done", {31'd0, done}, 0);
    end else begin
      #1 rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_res = '0;
    m_z   = 1'b0;
    m_c   = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", {31'd0, instr_ready}, 1);
    chk("abort_result", result, m_res);
    chk("abort_flags", {30'd0, flag_z, flag_c}, 0);
    check_rf("abort");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, instr_ready}, 1);
      chk("idle_enable", {31'd0, rf_enable}, 0);
      chk("idle_result", result, 0);
      chk("idle_flags", {30'd0, flag_z, flag_c}, 0);
    end

    seed(0, 32'h0);
    seed(1, 32'hFFFF_FFFF);
    seed(2, 32'h1);
    seed(3, 32'h0);

    issue(3'd1, 2'd3, 2'd1, 2'd2, 32'h0, 1'b0);
    chk("add_r3", rf_mem[3], 32'h0);
    chk("add_zc", {30'd0, flag_z, flag_c}, 32'd3);

    issue(3'd2, 2'd0, 2'd2, 2'd1, 32'h0, 1'b0);
    chk("sub_r0", rf_mem[0], 32'h2);
    chk("sub_zc", {30'd0, flag_z, flag_c}, 32'd1);

    issue(3'd6, 2'd2, 2'd2, 2'd2, 32'h0, 1'b1);
    chk("shl_r2", rf_mem[2], 32'h2);

    abort(3'd5, 2'd0, 2'd1, 2'd2, 1'b0);
    chk("xor_abort_r0", rf_mem[0], 32'h2);

    issue(3'd0, 2'd1, 2'd0, 2'd0, 32'hDEAD_BEEF, 1'b0);
`ifdef RF_SEQ_LDI_EN
    chk("ldi_r1", rf_mem[1], 32'hDEAD_BEEF);
`else
    chk("nop_r1", rf_mem[1], 32'hFFFF_FFFF);
`endif

    abort(3'd1, 2'd3, 2'd0, 2'd2, 1'b1);

    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom),
            2'($urandom), $urandom, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
